// File: rtl/decade_gate_ctrl_pkg.sv
// decade_gate_ctrl_pkg: shared FSM state type, BCD limit and counter-width helper
package decade_gate_ctrl_pkg;
  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_GATE, S_LATCH, S_HOLD} state_t;
  localparam logic [3:0] BCD_MAX = 4'd9;
  // A zero-length hold still needs a 1-bit timer to keep the vector legal.
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction
endpackage

// File: rtl/decade_gate_ctrl_bcd_digit.sv
// bcd_digit: one decade of the BCD cascade
//   clk, rst_n : clock, async active-low reset
//   clr        : synchronous clear to 0
//   inc        : advance by one, wrapping 9 -> 0
//   q, at9     : digit value, digit currently equals 9
module bcd_digit
  import decade_gate_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] q,
  output logic       at9
);
  logic [3:0] r_q;
  assign q   = r_q;
  assign at9 = r_q == BCD_MAX;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_q <= '0;
    else if (clr) r_q <= '0;
    else if (inc) r_q <= at9 ? 4'd0 : r_q + 4'd1;
endmodule

// File: rtl/decade_gate_ctrl.sv
// decade_gate_ctrl: gate-time sequencer counting input rising edges into a BCD cascade
//   clk, rst_n        : clock, async active-low reset
//   start, continuous : begin a measurement (IDLE only), loop after HOLD
//   in                : clk-synchronous event input
//   busy, done, valid : not idle, one-cycle result strobe, sticky result-present
//   ovf, result       : cascade wrapped past all-nines, latched BCD count
module decade_gate_ctrl
  import decade_gate_ctrl_pkg::*;
#(
  parameter int GATE_CYCLES = 1000,
  parameter int HOLD_CYCLES = 16,
  parameter int NUM_DIGITS  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    continuous,
  input  logic                    in,
  output logic                    busy,
  output logic                    done,
  output logic                    valid,
  output logic                    ovf,
  output logic [4*NUM_DIGITS-1:0] result
);
  localparam int GW = cnt_w(GATE_CYCLES);
  localparam int HW = cnt_w(HOLD_CYCLES);
  localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  state_t                  r_state, w_next, w_exit;
  logic                    r_in_d, r_ovf_flag, r_busy, r_done, r_valid, r_ovf;
  logic [GW-1:0]           r_gate_t;
  logic [HW-1:0]           r_hold_t;
  logic [4*NUM_DIGITS-1:0] r_result, w_digits;
  logic [NUM_DIGITS:0]     w_en;
  logic [NUM_DIGITS-1:0]   w_at9;
  logic                    w_clr;
  assign busy   = r_busy;
  assign done   = r_done;
  assign valid  = r_valid;
  assign ovf    = r_ovf;
  assign result = r_result;
  assign w_clr  = r_state == S_CLEAR;
  assign w_exit = continuous ? S_CLEAR : S_IDLE;
  // Carry enable into digit 0 is a gated rising edge; each higher digit also needs every lower digit at 9.
  assign w_en[0] = (r_state == S_GATE) & in & ~r_in_d;
  for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_dig
    bcd_digit u_dig (
      .clk  (clk),
      .rst_n(rst_n),
      .clr  (w_clr),
      .inc  (w_en[d]),
      .q    (w_digits[4*d +: 4]),
      .at9  (w_at9[d])
    );
    assign w_en[d+1] = w_en[d] & w_at9[d];
  end
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  w_next = start ? S_CLEAR : S_IDLE;
      S_CLEAR: w_next = S_GATE;
      S_GATE:  w_next = (r_gate_t == GATE_LAST) ? S_LATCH : S_GATE;
      S_LATCH: w_next = (HOLD_CYCLES == 0) ? w_exit : S_HOLD;
      S_HOLD:  w_next = (r_hold_t == HOLD_LAST) ? w_exit : S_HOLD;
      default: w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_in_d     <= 1'b0;
      r_gate_t   <= '0;
      r_hold_t   <= '0;
      r_ovf_flag <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_valid    <= 1'b0;
      r_ovf      <= 1'b0;
      r_result   <= '0;
    end else begin
      r_state    <= w_next;
      r_in_d     <= in;
      r_gate_t   <= (r_state == S_GATE) ? r_gate_t + 1'b1 : '0;
      r_hold_t   <= (r_state == S_HOLD) ? r_hold_t + 1'b1 : '0;
      r_ovf_flag <= w_clr ? 1'b0 : r_ovf_flag | w_en[NUM_DIGITS];
      r_busy     <= w_next != S_IDLE;
      r_done     <= r_state == S_LATCH;
      if (r_state == S_LATCH) begin
        r_result <= w_digits;
        r_ovf    <= r_ovf_flag;
        r_valid  <= 1'b1;
      end
    end
endmodule

// File: tb/tb_decade_gate_ctrl.sv
// tb_decade_gate_ctrl: directed checks of timing, BCD carry, overflow, continuous mode and reset
module tb_decade_gate_ctrl;
  logic        clk = 0, rst_n = 0, ev = 0, tog = 0;
  logic        start_a = 0, start_b = 0, start_c = 0;
  logic        cont_a = 0, cont_b = 0, cont_c = 0;
  logic        busy_a, done_a, valid_a, ovf_a;
  logic        busy_b, done_b, valid_b, ovf_b;
  logic        busy_c, done_c, valid_c, ovf_c;
  logic [15:0] result_a, result_b;
  logic [7:0]  result_c;
  int          n_cmp = 0, n_err = 0, k, nd;

  decade_gate_ctrl #(.GATE_CYCLES(20), .HOLD_CYCLES(4), .NUM_DIGITS(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .continuous(cont_a), .in(ev),
    .busy(busy_a), .done(done_a), .valid(valid_a), .ovf(ovf_a), .result(result_a));
  decade_gate_ctrl #(.GATE_CYCLES(250), .HOLD_CYCLES(16), .NUM_DIGITS(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .continuous(cont_b), .in(ev),
    .busy(busy_b), .done(done_b), .valid(valid_b), .ovf(ovf_b), .result(result_b));
  decade_gate_ctrl #(.GATE_CYCLES(250), .HOLD_CYCLES(0), .NUM_DIGITS(2)) dut_c (
    .clk(clk), .rst_n(rst_n), .start(start_c), .continuous(cont_c), .in(ev),
    .busy(busy_c), .done(done_c), .valid(valid_c), .ovf(ovf_c), .result(result_c));

  always #5 clk = ~clk;
  initial forever @(negedge clk) if (tog) ev = ~ev;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic done_of(input int sel);
    return (sel == 0) ? done_a : (sel == 1) ? done_b : done_c;
  endfunction

  task automatic pulse_a();
    @(negedge clk);
    start_a = 1;
    @(negedge clk);
    start_a = 0;
  endtask

  task automatic wait_done(input int sel, input int lim, output int cnt);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!done_of(sel) && cnt < lim);
    if (!done_of(sel)) chk("done_timeout", done_of(sel), 1);
  endtask

  task automatic wait_idle_a(input int lim, output int cnt);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (busy_a && cnt < lim);
    if (busy_a) chk("idle_timeout", busy_a, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_valid", valid_a, 0);
    chk("rst_ovf", ovf_a, 0);
    chk("rst_result", result_a, 0);
    rst_n = 1;
    tog = 1;
    pulse_a();
    wait_done(0, 100, k);
    chk("a_latency", k, 22);
    chk("a_result", result_a, 16'h0010);
    chk("a_valid", valid_a, 1);
    chk("a_ovf", ovf_a, 0);
    @(negedge clk);
    chk("a_done_width", done_a, 0);
    chk("a_busy_hold", busy_a, 1);
    wait_idle_a(20, k);
    chk("a_hold_len", k, 3);
    @(negedge clk);
    start_b = 1;
    start_c = 1;
    @(negedge clk);
    start_b = 0;
    start_c = 0;
    wait_done(1, 400, k);
    chk("b_latency", k, 252);
    chk("b_result", result_b, 16'h0125);
    chk("b_ovf", ovf_b, 0);
    chk("c_done", done_c, 1);
    chk("c_result", result_c, 8'h25);
    chk("c_ovf", ovf_c, 1);
    chk("c_valid", valid_c, 1);
    chk("c_busy_nohold", busy_c, 0);
    tog = 0;
    ev = 0;
    cont_a = 1;
    pulse_a();
    wait_done(0, 100, k);
    chk("cont_first", k, 22);
    chk("cont_result0", result_a, 0);
    repeat (2) begin
      wait_done(0, 100, k);
      chk("cont_period", k, 26);
      chk("cont_result", result_a, 0);
    end
    repeat (10) @(negedge clk);
    cont_a = 0;
    wait_done(0, 100, k);
    chk("cont_last", k, 16);
    wait_idle_a(20, k);
    chk("cont_exit", k, 4);
    nd = 0;
    repeat (60) begin
      @(negedge clk);
      if (done_a) nd++;
    end
    chk("cont_stopped", nd, 0);
    ev = 1;
    pulse_a();
    wait_done(0, 100, k);
    chk("held_high", result_a, 0);
    wait_idle_a(20, k);
    ev = 0;
    pulse_a();
    repeat (11) @(negedge clk);
    ev = 1;
    start_a = 1;
    @(negedge clk);
    start_a = 0;
    wait_done(0, 100, k);
    chk("single_edge", result_a, 1);
    nd = 0;
    repeat (60) begin
      @(negedge clk);
      if (done_a) nd++;
    end
    chk("start_ignored", nd, 0);
    chk("start_ign_busy", busy_a, 0);
    ev = 0;
    tog = 1;
    pulse_a();
    repeat (10) @(negedge clk);
    rst_n = 0;
    #1;
    chk("arst_busy", busy_a, 0);
    chk("arst_done", done_a, 0);
    chk("arst_valid", valid_a, 0);
    chk("arst_ovf", ovf_a, 0);
    chk("arst_result", result_a, 0);
    chk("arst_b_result", result_b, 0);
    @(negedge clk);
    rst_n = 1;
    pulse_a();
    wait_done(0, 100, k);
    chk("post_rst_latency", k, 22);
    chk("post_rst_result", result_a, 16'h0010);
    chk("post_rst_valid", valid_a, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/decade_gate_ctrl.md
# decade_gate_ctrl

Gate-time controller for a multi-digit BCD decade counter used as a frequency/event counter. It sequences clear, gated counting, result latch and hold phases, and counts synchronous rising edges of `in` into an internal cascade of decade digits during a programmable gate window. It sits between the event source and the display/readout logic and publishes a latched BCD result with a one-cycle `done` strobe.

## Interface
- `GATE_CYCLES`, 1000: length of the counting window in `clk` cycles, ≥1.
- `HOLD_CYCLES`, 16: idle cycles after each latch before the next measurement, ≥0; 0 skips HOLD.
- `NUM_DIGITS`, 4: number of cascaded decade digits, ≥1.
- `clk`  input  1  sole clock, rising-edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `start`  input  1  request one measurement; sampled in IDLE only.
- `continuous`  input  1  when high, the block loops back to CLEAR after HOLD instead of returning to IDLE.
- `in`  input  1  event input, already synchronous to `clk`.
- `busy`  output  1  high in every state except IDLE.
- `done`  output  1  one-cycle pulse when `result` updates.
- `valid`  output  1  `result` holds a completed measurement; sticky until reset.
- `ovf`  output  1  the latched measurement wrapped past all-nines.
- `result`  output  4*NUM_DIGITS  latched BCD count; digit 0 is in bits [3:0].

## Operation
- Edge detect: `in_d` is registered every cycle in all states. `edge = in & ~in_d`.
- FSM states: IDLE, CLEAR, GATE, LATCH, HOLD.
- IDLE: if `start`=1, go to CLEAR. Otherwise stay.
- CLEAR, 1 cycle: digits are cleared to 0, the internal overflow flag is cleared, and the gate timer is cleared. Next state is GATE.
- GATE, exactly GATE_CYCLES cycles: each `edge` increments the counter.
  - Digit i increments when `edge` is high and all lower digits equal 9.
  - A digit at 9 that increments wraps to 0.
  - If all digits are 9, an edge wraps the counter to all-zero and sets the internal overflow flag. The flag is sticky for the window.
  - The timer counts 0..GATE_CYCLES-1, then the FSM moves to LATCH.
- LATCH, 1 cycle: on the exit edge, `result` takes the digits, `ovf` takes the overflow flag, `valid` is set to 1, and `done` is set to 1 for one cycle. Next state is HOLD, or the HOLD-exit rule applies directly when HOLD_CYCLES is 0.
- HOLD, HOLD_CYCLES cycles: on exit, `continuous` is sampled. If it is 1, go to CLEAR; otherwise go to IDLE.
- Edges are ignored outside GATE. `start` is ignored outside IDLE.
- Digits never take values 10 to 15.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `valid`=0, `ovf`=0, `result`=0, `in_d`=0, digits 0, timer 0.
- Reset takes effect immediately and asynchronously, including mid-GATE. The aborted measurement is discarded and `result` returns to 0.
- `start` is sampled high at edge t.
  - CLEAR runs in cycle t+1.
  - GATE runs in cycles t+2 to t+1+G.
  - LATCH runs in cycle t+2+G.
  - `done`, `result` and `ovf` are visible in cycle t+3+G.
- `busy` is registered: it is high from cycle t+1 until the cycle after the HOLD-exit edge.
- Continuous mode: the `done` period is G+H+2 cycles.
- All outputs are registered. There are no combinational input-to-output paths.

## Structure
- Shared package: FSM state enum, and `BCD_MAX` = 4'd9.
- Sub-module `bcd_digit`: one decade with inputs `clk`, `rst_n`, `clr`, `inc` and outputs `q[3:0]`, `at9`. Instantiate it NUM_DIGITS times in a generate loop, with carry-enable built from an AND chain of lower-digit `at9`.
- The timer width is $clog2(GATE_CYCLES+1), and likewise for HOLD.

## Test plan
- Reset, G=20, `in` toggling every cycle, pulse `start` → 10 edges counted; `done` pulses at t+23; `result`=16'h0010; `valid`=1; `ovf`=0.
- G=250, `in` toggling every cycle → `result`=16'h0125, which checks digit carry across digits 0, 1 and 2.
- NUM_DIGITS=2, G=250, `in` toggling → `result`=8'h25, `ovf`=1.
- `continuous`=1, G=20, H=4, `in`=0 → `done` pulses every 26 cycles with `result`=0. Dropping `continuous` mid-GATE causes a return to IDLE after the next HOLD, and `busy` goes to 0.
- `in` held high from before CLEAR through GATE → `result`=0. A single 0→1 transition in mid-GATE → `result`=1.
- `start` pulsed during GATE is ignored: there is a single `done`. Assert `rst_n`=0 mid-GATE → all outputs are 0 immediately. A fresh `start` afterwards gives the correct count.
